// File: rtl/posit_unpack_seq.sv
// Multi-cycle posit field decoder: bit-serial regime scan, then field extraction.
//
// state  | meaning
// IDLE   | ready for a new posit
// SCAN   | examining one regime bit per cycle, MSB first
// FIELDS | computing k, exponent, mantissa and total exponent
// OUT    | result presented, waiting for out_ready
module posit_unpack_seq #(
    parameter int N         = 16,
    parameter int ES        = 1,
    parameter int K_SIZE    = $clog2(N) + 1,
    parameter int TE_SIZE   = K_SIZE + ES,
    parameter int MANT_SIZE = N - 2,
    localparam int EW       = (ES > 0) ? ES : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         posit_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign,
    output logic [K_SIZE-1:0]    k,
    output logic [EW-1:0]        exp,
    output logic [MANT_SIZE-1:0] mant,
    output logic [TE_SIZE-1:0]   total_exp,
    output logic                 is_zero,
    output logic                 is_nan
);

    typedef enum logic [1:0] {IDLE, SCAN, FIELDS, OUT} state_t;

    localparam logic [N-2:0]    LOW_ONE = 1;
    localparam logic [K_SIZE-1:0] K_ONE = 1;
    localparam logic [K_SIZE-1:0] IDX_TOP = K_SIZE'(N - 2);

    state_t state, state_next;

    logic [N-2:0]        sr;
    logic                r0;
    logic [K_SIZE-1:0]   m;
    logic [K_SIZE-1:0]   idx;

    logic                accept;
    logic                zero_in;
    logic                nar_in;
    logic [N-2:0]        abs_low;
    logic                scan_bit;
    logic                scan_done;

    logic [EW-1:0]       exp_f;
    logic [N-4:0]        frac_f;
    logic [K_SIZE-1:0]   k_f;
    logic [TE_SIZE-1:0]  te_f;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign zero_in   = (posit_in == '0);
    assign nar_in    = (posit_in == {1'b1, {(N-1){1'b0}}});
    // Only the low N-1 bits of |posit| are needed; the sign position of the magnitude is always 0.
    assign abs_low   = posit_in[N-1] ? (~posit_in[N-2:0] + LOW_ONE) : posit_in[N-2:0];
    assign scan_bit  = sr[N-2];
    assign scan_done = (scan_bit != r0) || (idx == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (zero_in || nar_in) ? OUT : SCAN;
            SCAN:    if (scan_done) state_next = FIELDS;
            FIELDS:  state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Field extraction from the bits left over after the run and terminator (left-aligned in sr).
    always_comb begin
        exp_f  = '0;
        frac_f = '0;
        for (int i = 0; i < ES; i++) begin
            if (N - 2 - i >= 0) exp_f[ES-1-i] = sr[N-2-i];
        end
        for (int i = 0; i < N - 3; i++) begin
            if (N - 2 - ES - i >= 0) frac_f[N-4-i] = sr[N-2-ES-i];
        end
        k_f  = r0 ? (m - K_ONE) : (-m);
        te_f = (TE_SIZE'($signed(k_f)) << ES) + TE_SIZE'(exp_f);
    end

    // Datapath: capture, regime scan and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            r0        <= 1'b0;
            m         <= '0;
            idx       <= '0;
            sign      <= 1'b0;
            k         <= '0;
            exp       <= '0;
            mant      <= '0;
            total_exp <= '0;
            is_zero   <= 1'b0;
            is_nan    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign      <= posit_in[N-1];
                        is_zero   <= zero_in;
                        is_nan    <= nar_in;
                        k         <= '0;
                        exp       <= '0;
                        mant      <= '0;
                        total_exp <= '0;
                        sr        <= abs_low;
                        r0        <= abs_low[N-2];
                        m         <= '0;
                        idx       <= IDX_TOP;
                    end
                end
                SCAN: begin
                    // Shift every cycle so the terminator also leaves sr.
                    sr <= sr << 1;
                    if (scan_bit == r0) m <= m + K_ONE;
                    if (idx != '0) idx <= idx - K_ONE;
                end
                FIELDS: begin
                    k         <= k_f;
                    exp       <= exp_f;
                    mant      <= {1'b1, frac_f};
                    total_exp <= te_f;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_unpack_seq.sv
// Bench for posit_unpack_seq (N=16, ES=1): reference decoder plus directed vectors.
module tb_posit_unpack_seq;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int KS = 5;
    localparam int TS = 6;
    localparam int MS = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  posit_in;
    logic          out_valid;
    logic          out_ready;
    logic          sign;
    logic [KS-1:0] k;
    logic [ES-1:0] exp;
    logic [MS-1:0] mant;
    logic [TS-1:0] total_exp;
    logic          is_zero;
    logic          is_nan;

    typedef struct {
        int sgn; int k; int e; int mant; int te; int zero; int nan; int lat;
    } res_t;

    res_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    posit_unpack_seq #(.N(N), .ES(ES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .posit_in(posit_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .k(k), .exp(exp), .mant(mant), .total_exp(total_exp),
        .is_zero(is_zero), .is_nan(is_nan)
    );

    always #5 clk = ~clk;

    // Reference decoder working on integers; lat counts edges from the accept edge inclusive.
    function automatic res_t model(input logic [15:0] p);
        res_t r;
        int a, r0, m, i, pos;
        r.sgn = 0; r.k = 0; r.e = 0; r.mant = 0; r.te = 0; r.zero = 0; r.nan = 0; r.lat = 1;
        if (p == 16'h0000) begin r.zero = 1; return r; end
        if (p == 16'h8000) begin r.nan = 1; r.sgn = 1; return r; end
        r.sgn = int'(p[15]);
        a = (r.sgn != 0) ? (65536 - int'(p)) : int'(p);
        r0 = (a >> 14) & 1;
        m = 0;
        i = 14;
        while (i >= 0 && ((a >> i) & 1) == r0) begin m++; i--; end
        pos = i - 1;
        r.k = (r0 != 0) ? m - 1 : -m;
        for (int j = 0; j < ES; j++) begin
            r.e = r.e * 2 + ((pos >= 0) ? ((a >> pos) & 1) : 0);
            pos--;
        end
        r.mant = 1 << (MS - 1);
        for (int b = MS - 2; b >= 0; b--) begin
            if (pos >= 0 && ((a >> pos) & 1) != 0) r.mant += (1 << b);
            pos--;
        end
        r.te  = r.k * (1 << ES) + r.e;
        r.lat = (((m + 1) < (N - 1)) ? (m + 1) : (N - 1)) + 2;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Compare every presented result against the model while out_valid is high.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("sign",      int'(sign),               q[0].sgn);
                chk("k",         int'($signed(k)),         q[0].k);
                chk("exp",       int'(exp),                q[0].e);
                chk("mant",      int'(mant),               q[0].mant);
                chk("total_exp", int'($signed(total_exp)), q[0].te);
                chk("is_zero",   int'(is_zero),            q[0].zero);
                chk("is_nan",    int'(is_nan),             q[0].nan);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic start(input logic [15:0] p, output int lat);
        int   w;
        res_t r;
        w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        chk("in_ready_before_accept", int'(in_ready), 1);
        r = model(p);
        posit_in = p;
        in_valid = 1'b1;
        q.push_back(r);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, r.lat);
    endtask

    task automatic finish_out(input int hold);
        for (int c = 0; c < hold; c++) begin
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready",  int'(in_ready),  0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drops", int'(out_valid), 0);
        chk("in_ready_rises",  int'(in_ready),  1);
    endtask

    logic [15:0] extra [5] = '{16'h6000, 16'h3000, 16'h9234, 16'h0123, 16'hFFFF};

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; posit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fields",    int'(sign) + int'(k) + int'(exp) + int'(mant) + int'(total_exp), 0);
        chk("rst_flags",     int'(is_zero) + int'(is_nan), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hand-computed literals; 3 edges after the accept edge = 4 counting it.
        start(16'h4000, lat);
        chk("lat_4000", lat, 4);
        chk("mant_4000", int'(mant), 'h2000);
        chk("te_4000", int'($signed(total_exp)), 0);
        finish_out(0);

        start(16'h4800, lat);
        chk("mant_4800", int'(mant), 'h3000);
        finish_out(0);

        start(16'h5000, lat);
        chk("exp_5000", int'(exp), 1);
        chk("te_5000", int'($signed(total_exp)), 1);
        finish_out(0);

        start(16'hC000, lat);
        chk("sign_C000", int'(sign), 1);
        chk("mant_C000", int'(mant), 'h2000);
        finish_out(0);

        start(16'h7FFF, lat);
        chk("lat_maxpos", lat, 17);
        chk("k_maxpos", int'($signed(k)), 14);
        chk("te_maxpos", int'($signed(total_exp)), 28);
        finish_out(0);

        start(16'h0001, lat);
        chk("lat_minpos", lat, 17);
        chk("k_minpos", int'($signed(k)), -14);
        chk("te_minpos", int'($signed(total_exp)), -28);
        finish_out(0);

        start(16'h0000, lat);
        chk("lat_zero", lat, 1);
        chk("zero_flag", int'(is_zero), 1);
        finish_out(0);

        start(16'h8000, lat);
        chk("lat_nar", lat, 1);
        chk("nar_flag", int'(is_nan), 1);
        chk("nar_sign", int'(sign), 1);
        finish_out(0);

        // Back-pressure with a competing request that must be ignored.
        start(16'h5000, lat);
        posit_in = 16'h7FFF;
        in_valid = 1'b1;
        finish_out(5);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_extra_accept_queue", q.size(), 0);

        // Reset while scanning maxpos.
        posit_in = 16'h7FFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("scan_no_out_valid", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", int'(in_ready), 1);
        for (int c = 0; c < 20; c++) begin
            chk("midrst_no_out_valid", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        start(16'h4000, lat);
        chk("post_rst_mant", int'(mant), 'h2000);
        finish_out(0);

        foreach (extra[i]) begin
            start(extra[i], lat);
            finish_out(1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
